// File: rtl/sw_pe_cfg_pkg.sv
// Shared types and helpers for the Smith-Waterman PE array.
// Saturating arithmetic is width-generic via a runtime width argument.
package sw_pkg;

  localparam int SYM_W_DNA  = 2;
  localparam int SYM_W_PROT = 5;

  localparam logic [1:0] NT_A = 2'd0;
  localparam logic [1:0] NT_C = 2'd1;
  localparam logic [1:0] NT_G = 2'd2;
  localparam logic [1:0] NT_T = 2'd3;

  function automatic logic signed [31:0] neg_inf(
    input int w
  );
    return -(32'sd1 <<< (w - 1));
  endfunction

  // Exact sum at 33 bits, then clamp to a w-bit signed range.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 w
  );
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) return hi[31:0];
    if (s < lo) return lo[31:0];
    return s[31:0];
  endfunction

endpackage

// File: rtl/sw_pe_cfg_if.sv
// Data/config bundle for one PE: chain inputs, programmable scores,
// and registered chain outputs.
interface sw_pe_cfg_if #(
  parameter int WIDTH   = 12,
  parameter int SYM_W   = 2,
  parameter int SCORE_W = 6,
  parameter int POS_W   = 16
);

  logic                      stall;
  logic                      local_mode;
  logic signed [SCORE_W-1:0] match_reward;
  logic signed [SCORE_W-1:0] mismatch_pen;
  logic signed [SCORE_W-1:0] gap_open_pen;
  logic signed [SCORE_W-1:0] gap_extend_pen;
  logic signed [WIDTH-1:0]   V_in;
  logic signed [WIDTH-1:0]   F_in;
  logic [SYM_W-1:0]          T_in;
  logic [SYM_W-1:0]          S_in;
  logic                      store_S_in;
  logic                      init_in;
  logic signed [WIDTH-1:0]   init_V;
  logic signed [WIDTH-1:0]   init_E;
  logic signed [WIDTH-1:0]   V_out;
  logic signed [WIDTH-1:0]   E_out;
  logic signed [WIDTH-1:0]   F_out;
  logic [SYM_W-1:0]          T_out;
  logic [SYM_W-1:0]          S_out;
  logic                      store_S_out;
  logic                      init_out;
  logic signed [WIDTH-1:0]   best_out;
  logic [POS_W-1:0]          best_pos_out;

  modport slave (
    input  stall, local_mode,
    input  match_reward, mismatch_pen,
    input  gap_open_pen, gap_extend_pen,
    input  V_in, F_in, T_in, S_in,
    input  store_S_in, init_in,
    input  init_V, init_E,
    output V_out, E_out, F_out,
    output T_out, S_out,
    output store_S_out, init_out,
    output best_out, best_pos_out
  );

  modport master (
    output stall, local_mode,
    output match_reward, mismatch_pen,
    output gap_open_pen, gap_extend_pen,
    output V_in, F_in, T_in, S_in,
    output store_S_in, init_in,
    output init_V, init_E,
    input  V_out, E_out, F_out,
    input  T_out, S_out,
    input  store_S_out, init_out,
    input  best_out, best_pos_out
  );

endinterface

// File: rtl/sw_max3_floor.sv
// Three-input signed max, optionally floored at zero.
// Ties resolve to the earliest input.
module sw_max3_floor #(
  parameter int WIDTH = 12
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  input  logic                    floor_en,
  output logic signed [WIDTH-1:0] y
);

  logic signed [WIDTH-1:0] ab;
  logic signed [WIDTH-1:0] abc;

  always_comb begin
    ab  = (b > a) ? b : a;
    abc = (c > ab) ? c : ab;
    y   = abc;
    if (floor_en && abc[WIDTH-1]) y = '0;
  end

endmodule

// File: rtl/sw_pe_cfg.sv
// One affine-gap Smith-Waterman systolic PE with runtime scores,
// saturation, global stall and best-score/position tracking.
module sw_pe_cfg
  import sw_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int SYM_W   = SYM_W_DNA,
  parameter int SCORE_W = 6,
  parameter int POS_W   = 16
) (
  input logic        clk,
  input logic        rst_n,
  sw_pe_cfg_if.slave bus
);

  localparam logic signed [WIDTH-1:0] NEG =
    WIDTH'(neg_inf(WIDTH));

  logic signed [WIDTH-1:0] v_q, e_q, f_q;
  logic signed [WIDTH-1:0] vd_q, best_q;
  logic [SYM_W-1:0]        t_q, s_q;
  logic                    init_q, sts_q;
  logic [POS_W-1:0]        pos_q, bpos_q;

  logic signed [SCORE_W-1:0] sub;
  logic signed [WIDTH-1:0]   e_open, e_ext;
  logic signed [WIDTH-1:0]   f_open, f_ext;
  logic signed [WIDTH-1:0]   new_e, new_f;
  logic signed [WIDTH-1:0]   diag, new_v;
  logic                      take_best;

  always_comb begin
    sub = (s_q == bus.T_in) ? bus.match_reward
                            : bus.mismatch_pen;
    e_open = WIDTH'(sat_add(32'(v_q),
               32'(bus.gap_open_pen), WIDTH));
    e_ext  = WIDTH'(sat_add(32'(e_q),
               32'(bus.gap_extend_pen), WIDTH));
    f_open = WIDTH'(sat_add(32'(bus.V_in),
               32'(bus.gap_open_pen), WIDTH));
    f_ext  = WIDTH'(sat_add(32'(bus.F_in),
               32'(bus.gap_extend_pen), WIDTH));
    diag   = WIDTH'(sat_add(32'(vd_q),
               32'(sub), WIDTH));
    new_e  = (e_ext > e_open) ? e_ext : e_open;
    new_f  = (f_ext > f_open) ? f_ext : f_open;
  end

  sw_max3_floor #(.WIDTH(WIDTH)) u_max (
    .a        (new_e),
    .b        (new_f),
    .c        (diag),
    .floor_en (bus.local_mode),
    .y        (new_v)
  );

  // First scored cycle of a run always seeds the tracker.
  assign take_best = bus.init_in &&
                     (!init_q || (new_v > best_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      e_q    <= '0;
      f_q    <= '0;
      vd_q   <= '0;
      best_q <= '0;
      t_q    <= '0;
      s_q    <= '0;
      init_q <= 1'b0;
      sts_q  <= 1'b0;
      pos_q  <= '0;
      bpos_q <= '0;
    end else if (!bus.stall) begin
      t_q    <= bus.T_in;
      vd_q   <= bus.V_in;
      init_q <= bus.init_in;
      sts_q  <= bus.store_S_in;
      if (bus.store_S_in) s_q <= bus.S_in;
      if (bus.init_in) begin
        v_q   <= new_v;
        e_q   <= new_e;
        f_q   <= new_f;
        pos_q <= pos_q + POS_W'(1);
      end else begin
        v_q   <= bus.init_V;
        e_q   <= bus.init_E;
        f_q   <= NEG;
        pos_q <= '0;
      end
      if (take_best) begin
        best_q <= new_v;
        bpos_q <= pos_q;
      end
    end
  end

  assign bus.V_out        = v_q;
  assign bus.E_out        = e_q;
  assign bus.F_out        = f_q;
  assign bus.T_out        = t_q;
  assign bus.S_out        = s_q;
  assign bus.store_S_out  = sts_q;
  assign bus.init_out     = init_q;
  assign bus.best_out     = best_q;
  assign bus.best_pos_out = bpos_q;

endmodule

// File: tb/tb_sw_pe_cfg.sv
// Randomized and directed bench for sw_pe_cfg against an
// integer reference model of the recurrence.
module tb_sw_pe_cfg;
  import sw_pkg::*;

  localparam int W   = 8;
  localparam int SW  = 2;
  localparam int SCW = 6;
  localparam int PW  = 4;
  localparam int LIM = 1 << (W - 1);

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  int m_v, m_e, m_f, m_vd, m_best, m_bpos;
  int m_pos, m_t, m_s, m_init, m_sts;

  sw_pe_cfg_if #(
    .WIDTH(W), .SYM_W(SW), .SCORE_W(SCW), .POS_W(PW)
  ) bus ();

  sw_pe_cfg #(
    .WIDTH(W), .SYM_W(SW), .SCORE_W(SCW), .POS_W(PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(int x);
    if (x > LIM - 1) return LIM - 1;
    if (x < -LIM) return -LIM;
    return x;
  endfunction

  function automatic int imax(int a, int b);
    return (b > a) ? b : a;
  endfunction

  task automatic m_reset();
    m_v = 0; m_e = 0; m_f = 0; m_vd = 0;
    m_best = 0; m_bpos = 0; m_pos = 0;
    m_t = 0; m_s = 0; m_init = 0; m_sts = 0;
  endtask

  // Cell recurrence straight from the scoring rules.
  task automatic m_step();
    int vin, fin, go, ge, sc, nv, ne, nf;
    if (!rst_n) begin
      m_reset();
      return;
    end
    if (bus.stall) return;
    vin = int'(bus.V_in);
    fin = int'(bus.F_in);
    go  = int'(bus.gap_open_pen);
    ge  = int'(bus.gap_extend_pen);
    sc  = (m_s == int'(bus.T_in)) ?
          int'(bus.match_reward) : int'(bus.mismatch_pen);
    ne = imax(clamp(m_v + go), clamp(m_e + ge));
    nf = imax(clamp(vin + go), clamp(fin + ge));
    nv = imax(imax(ne, nf), clamp(m_vd + sc));
    if (bus.local_mode) nv = imax(nv, 0);
    if (bus.init_in) begin
      if (m_init == 0 || nv > m_best) begin
        m_best = nv;
        m_bpos = m_pos;
      end
      m_v = nv; m_e = ne; m_f = nf;
      m_pos = (m_pos + 1) % (1 << PW);
    end else begin
      m_v = int'(bus.init_V);
      m_e = int'(bus.init_E);
      m_f = -LIM;
      m_pos = 0;
    end
    m_t = int'(bus.T_in);
    m_vd = vin;
    m_init = int'(bus.init_in);
    m_sts = int'(bus.store_S_in);
    if (bus.store_S_in) m_s = int'(bus.S_in);
  endtask

  task automatic cmp_all(string tag);
    chk({tag, ".V"}, int'(bus.V_out), m_v);
    chk({tag, ".E"}, int'(bus.E_out), m_e);
    chk({tag, ".F"}, int'(bus.F_out), m_f);
    chk({tag, ".T"}, int'(bus.T_out), m_t);
    chk({tag, ".S"}, int'(bus.S_out), m_s);
    chk({tag, ".init"}, int'(bus.init_out), m_init);
    chk({tag, ".sts"}, int'(bus.store_S_out), m_sts);
    chk({tag, ".best"}, int'(bus.best_out), m_best);
    chk({tag, ".bpos"}, int'(bus.best_pos_out), m_bpos);
  endtask

  task automatic tick(string tag);
    m_step();
    @(posedge clk);
    #1;
    cmp_all(tag);
  endtask

  task automatic scores(int lm, int mr, int mm, int go, int ge);
    bus.local_mode     = lm[0];
    bus.match_reward   = SCW'(mr);
    bus.mismatch_pen   = SCW'(mm);
    bus.gap_open_pen   = SCW'(go);
    bus.gap_extend_pen = SCW'(ge);
  endtask

  task automatic preload(int vin, int iv, int ie);
    bus.init_in    = 1'b0;
    bus.store_S_in = 1'b0;
    bus.V_in       = W'(vin);
    bus.F_in       = W'(-LIM);
    bus.init_V     = W'(iv);
    bus.init_E     = W'(ie);
    tick("pre");
  endtask

  function automatic int rnd_s(int lo, int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  initial begin
    int tseq[4];
    int vexp[4];
    tseq = '{int'(NT_A), int'(NT_C), int'(NT_A), int'(NT_A)};
    vexp = '{2, 0, 2, 2};
    bus.stall = 1'b0;
    scores(0, 0, 0, 0, 0);
    bus.V_in = '0; bus.F_in = '0;
    bus.T_in = '0; bus.S_in = '0;
    bus.store_S_in = 1'b0; bus.init_in = 1'b0;
    bus.init_V = '0; bus.init_E = '0;
    m_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 cmp_all("rst0");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // DNA local scoring, earliest tie kept
    scores(1, 2, -2, -2, -1);
    bus.store_S_in = 1'b1;
    bus.S_in = NT_A;
    bus.V_in = '0; bus.F_in = '0;
    bus.init_V = '0; bus.init_E = '0;
    tick("t2ld");
    bus.store_S_in = 1'b0;
    bus.init_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.T_in = SW'(tseq[i]);
      tick("t2");
      chk("t2.Vlit", int'(bus.V_out), vexp[i]);
    end
    bus.init_in = 1'b0;
    tick("t2end");
    chk("t2.best", int'(bus.best_out), 2);
    chk("t2.bpos", int'(bus.best_pos_out), 0);

    // Positive and negative saturation
    scores(1, 31, -2, -2, -1);
    preload(120, 0, 0);
    bus.init_in = 1'b1;
    bus.T_in = NT_A;
    bus.V_in = '0;
    tick("t3p");
    chk("t3.pos_sat", int'(bus.V_out), 127);
    scores(0, 31, -32, -32, -32);
    preload(-120, -120, -LIM);
    bus.init_in = 1'b1;
    bus.T_in = NT_C;
    bus.V_in = W'(-120);
    tick("t3n");
    chk("t3.neg_sat", int'(bus.V_out), -128);

    // Global mode keeps negative scores
    scores(0, 2, -2, -2, -1);
    preload(-5, -5, -LIM);
    bus.init_in = 1'b1;
    bus.T_in = NT_G;
    bus.V_in = W'(-5);
    tick("t4");
    chk("t4.glob", int'(bus.V_out), -7);

    // Position counter wraps; peak at run cycle 17
    scores(1, 0, 0, -32, -32);
    preload(0, 0, -LIM);
    bus.init_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.V_in = W'((k < 16) ? k : ((k == 16) ? 50 : 0));
      bus.T_in = SW'($urandom_range(3));
      tick("t6");
    end
    bus.init_in = 1'b0;
    tick("t6end");
    chk("t6.best", int'(bus.best_out), 50);
    chk("t6.bpos", int'(bus.best_pos_out), 1);

    // Random runs with stalls and mid-run S loads
    for (int r = 0; r < 4; r++) begin
      scores(int'($urandom_range(1)), rnd_s(-32, 31),
             rnd_s(-32, 31), rnd_s(-32, 31), rnd_s(-32, 31));
      bus.store_S_in = 1'b1;
      bus.S_in = SW'($urandom_range(3));
      bus.V_in = W'(rnd_s(-LIM, LIM - 1));
      bus.init_V = W'(rnd_s(-LIM, LIM - 1));
      bus.init_E = W'(rnd_s(-LIM, LIM - 1));
      tick("rld");
      bus.init_in = 1'b1;
      for (int c = 0; c < 30; c++) begin
        bus.stall = (c >= 10 && c < 13) ||
                    ($urandom_range(4) == 0);
        bus.store_S_in = ($urandom_range(7) == 0);
        bus.S_in = SW'($urandom_range(3));
        bus.T_in = SW'($urandom_range(3));
        bus.V_in = W'(rnd_s(-LIM, LIM - 1));
        bus.F_in = W'(rnd_s(-LIM, LIM - 1));
        tick("rnd");
      end
      bus.stall = 1'b0;
      bus.store_S_in = 1'b0;
      bus.init_in = 1'b0;
      tick("rend");
    end

    // Asynchronous reset in the middle of a run
    scores(1, 2, -2, -2, -1);
    preload(10, 5, 0);
    bus.init_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.V_in = W'(rnd_s(0, 60));
      bus.T_in = SW'($urandom_range(3));
      tick("pre_rst");
    end
    #3 rst_n = 1'b0;
    m_reset();
    #1 cmp_all("arst");
    tick("arst_hold");
    rst_n = 1'b1;
    bus.init_in = 1'b0;
    tick("arst_rel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
